// File: rtl/sha256_mem_arbiter.sv
// Round-robin arbiter sharing one word-addressed memory port between
// hashing engines, with locked bursts capped at MAX_BURST grants.
module sha256_mem_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0]      req_lock,
  input  logic [NUM_REQ-1:0]      req_we,
  input  logic [16*NUM_REQ-1:0]   req_addr,
  input  logic [32*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]      req_gnt,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [31:0]             rsp_data,
  output logic                    mem_we,
  output logic [15:0]             mem_addr,
  output logic [31:0]             mem_write_data,
  input  logic [31:0]             mem_read_data
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0]      rr_ptr, rr_nxt;
  logic [IW-1:0]      owner_idx, owner_nxt;
  logic [IW-1:0]      gnt_idx;
  logic               owner_valid, owner_vnxt;
  logic               owner_hit, gnt_any, lock_ok;
  logic [7:0]         burst_cnt, cnt_nxt, cnt_base;
  logic [8:0]         cnt_inc;
  logic [NUM_REQ-1:0] rd_pend;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
    return IW'((int'(i) + 1) % NUM_REQ);
  endfunction

  // Owner keeps the port; otherwise lowest offset from rr_ptr wins.
  always_comb begin
    owner_hit = owner_valid && req_valid[owner_idx];
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    if (owner_hit) begin
      gnt_any = 1'b1;
      gnt_idx = owner_idx;
    end else begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (req_valid[(int'(rr_ptr) + i) % NUM_REQ]) begin
          gnt_any = 1'b1;
          gnt_idx = IW'((int'(rr_ptr) + i) % NUM_REQ);
        end
      end
    end
    if (reset) gnt_any = 1'b0;
  end

  always_comb begin
    req_gnt        = '0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    if (gnt_any) begin
      req_gnt[gnt_idx] = 1'b1;
      mem_we           = req_we[gnt_idx];
      mem_addr         = req_addr[gnt_idx*16 +: 16];
      mem_write_data   = req_wdata[gnt_idx*32 +: 32];
    end
  end

  // A new owner starts its burst count from zero.
  always_comb begin
    cnt_base   = owner_hit ? burst_cnt : 8'd0;
    cnt_inc    = {1'b0, cnt_base} + 9'd1;
    lock_ok    = req_lock[gnt_idx] && (int'(cnt_inc) < MAX_BURST);
    rr_nxt     = rr_ptr;
    owner_vnxt = owner_valid;
    owner_nxt  = owner_idx;
    cnt_nxt    = burst_cnt;
    if (owner_valid && !owner_hit) begin
      rr_nxt     = wrap_inc(owner_idx);
      owner_vnxt = 1'b0;
      cnt_nxt    = 8'd0;
    end
    if (gnt_any) begin
      if (lock_ok) begin
        owner_vnxt = 1'b1;
        owner_nxt  = gnt_idx;
        cnt_nxt    = cnt_inc[7:0];
      end else begin
        owner_vnxt = 1'b0;
        cnt_nxt    = 8'd0;
        rr_nxt     = wrap_inc(gnt_idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr      <= '0;
      owner_valid <= 1'b0;
      owner_idx   <= '0;
      burst_cnt   <= '0;
      rd_pend     <= '0;
    end else begin
      rr_ptr      <= rr_nxt;
      owner_valid <= owner_vnxt;
      owner_idx   <= owner_nxt;
      burst_cnt   <= cnt_nxt;
      rd_pend     <= req_gnt & ~{NUM_REQ{mem_we}};
    end
  end

  assign rsp_valid = rd_pend & ~{NUM_REQ{reset}};
  assign rsp_data  = mem_read_data;

endmodule

// File: doc/sha256_mem_arbiter.md
Name: sha256_mem_arbiter

Overview:
- Round-robin arbiter that shares the single word-addressed memory port between NUM_REQ hashing engines. Each engine is a simplified SHA-256 core issuing block reads and hash writes.
- Sits between the engine array and the message/output memory.
- Supports locked bursts, so an engine can fetch a 16-word block back-to-back. A MAX_BURST limit bounds starvation.
- Routes one-cycle-latency read data back to the issuing engine.

Parameters:
- NUM_REQ, 4, number of requesting engines (2..8)
- MAX_BURST, 16, maximum consecutive grants to one locked owner before forced release (1..255)

Ports:
- clk  in  1  clock; memory also runs on clk
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  requester k wants an access this cycle
- req_lock  in  NUM_REQ  requester k wants to keep the port after this access
- req_we  in  NUM_REQ  1=write, 0=read
- req_addr  in  16*NUM_REQ  word address; slice k is bits [16k+15:16k]
- req_wdata  in  32*NUM_REQ  write data; slice k is bits [32k+31:32k]
- req_gnt  out  NUM_REQ  one-hot; access of requester k is issued this cycle
- rsp_valid  out  NUM_REQ  one-hot; rsp_data answers requester k's read from the previous cycle
- rsp_data  out  32  read data, shared by all requesters
- mem_we  out  1  memory write enable
- mem_addr  out  16  memory word address
- mem_write_data  out  32  memory write data
- mem_read_data  in  32  memory read data, valid the cycle after the address is presented

Behaviour:
- Single clock domain. Reset is sampled on the clk rising edge only.
- State registers: rr_ptr (next priority index), owner_valid, owner_idx, burst_cnt (8 bit), rd_pend (NUM_REQ-bit one-hot).
- Reset values:
  - rr_ptr=0, owner_valid=0, burst_cnt=0, rd_pend=0.
  - While reset=1, the combinational outputs req_gnt, mem_we, mem_addr and mem_write_data are forced to 0.
  - rsp_valid=0 during reset and in the cycle after reset deasserts.
- Grant selection is combinational in the same cycle:
  - If owner_valid and req_valid[owner_idx]: grant owner_idx.
  - Otherwise, grant the first k with req_valid[k]=1, searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - If there is no request: req_gnt=0, mem_we=0, mem_addr=0, mem_write_data=0.
- Granted access:
  - mem_we=req_we[g], mem_addr=req_addr slice g, mem_write_data=req_wdata slice g.
  - Zero-cycle latency from request to memory.
- Lock / burst (registered on the grant edge):
  - If req_lock[g]=1 and burst_cnt+1 < MAX_BURST: owner_valid=1, owner_idx=g, burst_cnt++.
  - Otherwise: owner_valid=0, burst_cnt=0, rr_ptr=(g+1) mod NUM_REQ.
  - If the owner drops req_valid while owner_valid=1: release with no grant charged to it. rr_ptr=(owner_idx+1) mod NUM_REQ, burst_cnt=0. The fallback round-robin search runs in that same cycle, starting at the old rr_ptr.
  - Forced release at MAX_BURST: the owner's MAX_BURST-th consecutive grant is its last. The next cycle starts round-robin from g+1.
- Read return:
  - rd_pend <= req_gnt & ~{NUM_REQ{mem_we}} each cycle.
  - rsp_valid=rd_pend; rsp_data=mem_read_data (combinational pass-through).
  - Latency is exactly 1 cycle. Writes produce no response.
- Requesters hold req_* stable until they see req_gnt. Dropping req_valid without a grant is legal and has no effect.
- Simultaneous events:
  - A new read granted in the same cycle as a pending response is supported; the pipeline is fully overlapped.
  - Reset mid-burst or mid-read clears the owner and drops the pending rsp_valid; no response is delivered.
- Width rule: rr_ptr and owner_idx are $clog2(NUM_REQ) bits; wrap is via explicit modulo, not natural overflow, for non-power-of-2 NUM_REQ.

Test Plan:
- Reset: hold reset 3 cycles with all req_valid=1 -> req_gnt=0, mem_we=0, rsp_valid=0. After release, first grant goes to requester 0.
- Fairness: NUM_REQ=4, all valid, lock=0, reads to addr 0x10+k -> grants 0,1,2,3,0,… one per cycle. rsp_valid one-hot follows grants by 1 cycle. rsp_data matches memory contents at 0x10+k.
- Locked burst: req 2 lock=1 for 16 reads at 0x0000..0x000F, req 0 also valid -> req 2 granted 16 consecutive cycles (MAX_BURST=16). req 0 is granted in cycle 17.
- Forced release: MAX_BURST=4, req 1 lock held for 10 words, req 3 valid -> grant pattern 1,1,1,1,3,1,1,1,1,…
- Writes: req 0 writes 0xDEADBEEF to 0x0100, req 1 reads 0x0100 the next cycle -> mem_we=1 with correct addr/data; req 1's rsp_data=0xDEADBEEF; no rsp_valid for req 0.
- Owner drop and reset mid-op: owner 2 drops req_valid mid-burst -> next grant goes round-robin from 3. Assert reset in the cycle after a read grant -> no rsp_valid; rr_ptr returns to 0.
